// File: rtl/grid_ram.sv
// grid_ram: WIDTH x HEIGHT game-board memory, CELL_BITS per cell.
//
// Port A (a_x, a_y -> a_data) is a read-only display port. It is sampled on
// every rising edge, including during a clear sweep. Out-of-range coordinates
// read as 0.
//
// Port B (b_req/b_we/b_x/b_y/b_wdata -> b_ready/b_rvalid/b_rdata/b_err) is
// the game-logic port. A request is accepted when b_req && b_ready.
// - Reads return data one cycle later with a b_rvalid pulse.
// - Out-of-range coordinates pulse b_err, read back 0 and never write.
//
// clear_req starts a sweep that writes CLEAR_VAL to every cell, one cell per
// cycle. The same sweep runs automatically after reset. busy is high during
// a sweep, and port B is not ready while it runs.
//
// Optional build macro GRID_RAM_XCHG_EN: a port B write becomes an exchange.
// It returns the old cell value with b_rvalid and writes the new value in the
// same cycle.
module grid_ram #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned HEIGHT    = 16,
    parameter int unsigned CELL_BITS = 4,
    parameter logic [CELL_BITS-1:0] CLEAR_VAL = '0,
    localparam int unsigned XW    = $clog2(WIDTH),
    localparam int unsigned YW    = $clog2(HEIGHT),
    localparam int unsigned CELLS = WIDTH * HEIGHT,
    localparam int unsigned AW    = $clog2(CELLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XW-1:0]        a_x,
    input  logic [YW-1:0]        a_y,
    output logic [CELL_BITS-1:0] a_data,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [XW-1:0]        b_x,
    input  logic [YW-1:0]        b_y,
    input  logic [CELL_BITS-1:0] b_wdata,
    output logic                 b_ready,
    output logic                 b_rvalid,
    output logic [CELL_BITS-1:0] b_rdata,
    output logic                 b_err,
    input  logic                 clear_req,
    output logic                 busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Cell storage: no reset, so it maps onto block RAM.
    logic [CELL_BITS-1:0] mem [CELLS];

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [CELL_BITS-1:0] a_data_q, a_data_d;
    logic [CELL_BITS-1:0] b_rdata_q, b_rdata_d;
    logic                 b_rvalid_q, b_rvalid_d;
    logic                 b_err_q, b_err_d;

    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [CELL_BITS-1:0] mem_wdata;

    logic [AW-1:0]        a_addr, b_addr;
    logic                 a_in_range, b_in_range;
    logic                 b_accept;

    // Row-major address at full 32-bit precision, narrowed only at the end.
    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
        logic [31:0] full;
        full = 32'(y) * 32'(WIDTH) + 32'(x);
        return AW'(full);
    endfunction

    // Only reachable as false for non-power-of-2 dimensions.
    function automatic logic coord_ok(input logic [XW-1:0] x,
                                      input logic [YW-1:0] y);
        return (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
    endfunction

    // Address decode for both ports.
    always_comb begin
        a_addr     = cell_addr(a_x, a_y);
        b_addr     = cell_addr(b_x, b_y);
        a_in_range = coord_ok(a_x, a_y);
        b_in_range = coord_ok(b_x, b_y);
        b_accept   = b_req && ready_q;
    end

    // Next-state, response and memory-write decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        b_rdata_d  = b_rdata_q;
        b_rvalid_d = 1'b0;
        b_err_d    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = CLEAR_VAL;
        // Port A reads the array before any write this edge (read-first).
        a_data_d   = a_in_range ? mem[a_addr] : '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (cnt_q == AW'(CELLS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (b_accept) begin
                    b_err_d = !b_in_range;
                    if (b_we) begin
                        mem_we    = b_in_range;
                        mem_waddr = b_addr;
                        mem_wdata = b_wdata;
`ifdef GRID_RAM_XCHG_EN
                        // Exchange: hand back the pre-write contents.
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = b_in_range ? mem[b_addr] : '0;
`endif
                    end else begin
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = b_in_range ? mem[b_addr] : '0;
                    end
                end
                // A same-cycle B write lands first; the sweep then overwrites it.
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            a_data_q   <= '0;
            b_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            a_data_q   <= a_data_d;
            b_rdata_q  <= b_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
        end
    end

    // Single write port shared by the sweep and port B.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign a_data   = a_data_q;
    assign b_rdata  = b_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_err    = b_err_q;
    assign b_ready  = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_grid_ram.sv
// Bench for grid_ram: a 32x16 board checked against a cell-array model, and a
// 20x12 board exercising out-of-range coordinates.
module tb_grid_ram;

`ifdef GRID_RAM_XCHG_EN
    localparam bit XCHG = 1'b1;
`else
    localparam bit XCHG = 1'b0;
`endif

    localparam int W = 32;
    localparam int H = 16;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] a_x, b_x;
    logic [3:0] a_y, b_y;
    logic [3:0] a_data, b_wdata, b_rdata;
    logic       b_req, b_we, b_ready, b_rvalid, b_err, clear_req, busy;

    logic [4:0] u2_a_x, u2_b_x;
    logic [3:0] u2_a_y, u2_b_y;
    logic [3:0] u2_a_data, u2_b_wdata, u2_b_rdata;
    logic       u2_b_req, u2_b_we, u2_b_ready, u2_b_rvalid, u2_b_err;
    logic       u2_clear_req, u2_busy;

    always #5 clk = ~clk;

    grid_ram dut (
        .clk(clk), .rst_n(rst_n), .a_x(a_x), .a_y(a_y), .a_data(a_data),
        .b_req(b_req), .b_we(b_we), .b_x(b_x), .b_y(b_y), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .clear_req(clear_req), .busy(busy)
    );

    grid_ram #(.WIDTH(20), .HEIGHT(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .a_x(u2_a_x), .a_y(u2_a_y), .a_data(u2_a_data),
        .b_req(u2_b_req), .b_we(u2_b_we), .b_x(u2_b_x), .b_y(u2_b_y),
        .b_wdata(u2_b_wdata), .b_ready(u2_b_ready), .b_rvalid(u2_b_rvalid),
        .b_rdata(u2_b_rdata), .b_err(u2_b_err), .clear_req(u2_clear_req),
        .busy(u2_busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: board contents, sweep writes still owed, held read data.
    logic [3:0] m_mem   [N];
    bit         m_known [N];
    int         clear_left;
    logic [3:0] m_rdata;
    bit         p_rvalid;
    logic [3:0] p_adata;
    bit         p_adata_known;

    // Drive one cycle of main-board inputs, advance the model, wait for the edge.
    task automatic cycle(input bit req, input bit we, input int x, input int y,
                         input int wd, input bit cr, input int ax, input int ay);
        int ai;
        int bi;
        b_req = req; b_we = we; b_x = 5'(x); b_y = 4'(y); b_wdata = 4'(wd);
        clear_req = cr; a_x = 5'(ax); a_y = 4'(ay);
        ai = ay * W + ax;
        bi = y * W + x;
        p_adata       = m_mem[ai];
        p_adata_known = m_known[ai];
        p_rvalid      = 1'b0;
        if (clear_left > 0) begin
            m_mem[N - clear_left]   = 4'h0;
            m_known[N - clear_left] = 1'b1;
            clear_left--;
        end else begin
            if (req) begin
                if (!we || XCHG) begin
                    p_rvalid = 1'b1;
                    m_rdata  = m_mem[bi];
                end
                if (we) begin
                    m_mem[bi]   = 4'(wd);
                    m_known[bi] = 1'b1;
                end
            end
            if (cr) clear_left = N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},   32'(busy),     32'(clear_left > 0));
        chk({tag, ".ready"},  32'(b_ready),  32'(clear_left == 0));
        chk({tag, ".rvalid"}, 32'(b_rvalid), 32'(p_rvalid));
        chk({tag, ".err"},    32'(b_err),    32'(0));
        chk({tag, ".rdata"},  32'(b_rdata),  32'(m_rdata));
        if (p_adata_known) chk({tag, ".adata"}, 32'(a_data), 32'(p_adata));
    endtask

    task automatic u2_op(input bit req, input bit we, input int x, input int y,
                         input int wd, input int ax, input int ay);
        u2_b_req = req; u2_b_we = we; u2_b_x = 5'(x); u2_b_y = 4'(y);
        u2_b_wdata = 4'(wd); u2_a_x = 5'(ax); u2_a_y = 4'(ay);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit req; bit we; int x; int y; int wd; int ax; int ay;
        bit rv; int rd; int ad;
    } vec_t;

    vec_t tbl [12];
    int   busy_cnt;
    int   e;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed sequence on a cleared board: {req,we,x,y,wd,ax,ay, rvalid,rdata,adata}
        tbl[0]  = '{1, 1,  5,  3, 'hA,  5,  3, XCHG, 0,                 0};
        tbl[1]  = '{1, 0,  5,  3, 0,    5,  3, 1,    'hA,               'hA};
        tbl[2]  = '{1, 1,  0,  0, 'h9,  0,  0, XCHG, XCHG ? 0 : 'hA,    0};
        tbl[3]  = '{1, 1,  0,  0, 'h3,  0,  0, XCHG, XCHG ? 'h9 : 'hA,  'h9};
        tbl[4]  = '{0, 0,  0,  0, 0,    0,  0, 0,    XCHG ? 'h9 : 'hA,  'h3};
        tbl[5]  = '{1, 0,  0,  0, 0,    0,  0, 1,    'h3,               'h3};
        tbl[6]  = '{1, 1, 10,  2, 'h5, 10,  2, XCHG, XCHG ? 0 : 'h3,    0};
        tbl[7]  = '{1, 1, 10,  2, 'h2, 10,  2, XCHG, XCHG ? 'h5 : 'h3,  'h5};
        tbl[8]  = '{1, 0, 10,  2, 0,   10,  2, 1,    'h2,               'h2};
        tbl[9]  = '{1, 0, 31, 15, 0,   31, 15, 1,    0,                 0};
        tbl[10] = '{1, 1, 31, 15, 'h7, 31, 15, XCHG, 0,                 0};
        tbl[11] = '{1, 0, 31, 15, 0,   31, 15, 1,    'h7,               'h7};

        rst_n = 1'b0;
        b_req = 0; b_we = 0; b_x = 0; b_y = 0; b_wdata = 0; clear_req = 0; a_x = 0; a_y = 0;
        u2_b_req = 0; u2_b_we = 0; u2_b_x = 0; u2_b_y = 0; u2_b_wdata = 0;
        u2_clear_req = 0; u2_a_x = 0; u2_a_y = 0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst.a_data",   32'(a_data),   32'(0));
        chk("rst.b_rdata",  32'(b_rdata),  32'(0));
        chk("rst.b_rvalid", 32'(b_rvalid), 32'(0));
        chk("rst.b_err",    32'(b_err),    32'(0));
        chk("rst.busy",     32'(busy),     32'(1));
        chk("rst.b_ready",  32'(b_ready),  32'(0));
        chk("rst.u2_busy",  32'(u2_busy),  32'(1));

        // Power-up sweep: requests and clear_req are dropped while busy.
        rst_n      = 1'b1;
        clear_left = N;
        m_rdata    = 4'h0;
        busy_cnt   = busy ? 1 : 0;
        for (int k = 0; k < 600; k++) begin
            cycle(clear_left > 0 ? 1'($urandom_range(1, 0)) : 1'b0, 1'($urandom_range(1, 0)),
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(15, 0)),
                  clear_left > 0 ? 1'($urandom_range(1, 0)) : 1'b0,
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)));
            check_model("sweep");
            if (busy) busy_cnt++;
        end
        chk("init_busy_len", 32'(busy_cnt), 32'(N));

        // Full scan through port B: every cell must have been cleared.
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cycle(1'b1, 1'b0, x, y, 0, 1'b0, x, y);
                check_model("scan");
            end
        end

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].req, tbl[i].we, tbl[i].x, tbl[i].y, tbl[i].wd, 1'b0, tbl[i].ax, tbl[i].ay);
            chk($sformatf("tbl%0d.rvalid", i), 32'(b_rvalid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d.rdata", i),  32'(b_rdata),  32'(tbl[i].rd));
            chk($sformatf("tbl%0d.err", i),    32'(b_err),    32'(0));
            chk($sformatf("tbl%0d.adata", i),  32'(a_data),   32'(tbl[i].ad));
        end

        // Non-power-of-2 board: out-of-range requests flag b_err and never write.
        b_req = 0; clear_req = 0;
        for (int k = 0; k < 300 && u2_busy; k++) u2_op(0, 0, 0, 0, 0, 0, 0);
        chk("u2.idle", 32'(u2_busy), 32'(0));
        u2_op(1, 0, 25, 3, 0, 25, 3);
        chk("u2.oor_rd.rvalid", 32'(u2_b_rvalid), 32'(1));
        chk("u2.oor_rd.rdata",  32'(u2_b_rdata),  32'(0));
        chk("u2.oor_rd.err",    32'(u2_b_err),    32'(1));
        chk("u2.oor_rd.adata",  32'(u2_a_data),   32'(0));
        u2_op(1, 0, 5, 13, 0, 0, 0);
        chk("u2.oor_y.err",     32'(u2_b_err),    32'(1));
        u2_op(1, 1, 19, 11, 'hC, 19, 11);
        chk("u2.corner_wr.err",    32'(u2_b_err),    32'(0));
        chk("u2.corner_wr.rvalid", 32'(u2_b_rvalid), 32'(XCHG));
        u2_op(1, 0, 19, 11, 0, 19, 11);
        chk("u2.corner_rd.rdata", 32'(u2_b_rdata), 32'('hC));
        chk("u2.corner_rd.adata", 32'(u2_a_data),  32'('hC));
        u2_op(1, 1, 25, 3, 'hF, 25, 3);
        chk("u2.oor_wr.err",    32'(u2_b_err),    32'(1));
        chk("u2.oor_wr.rvalid", 32'(u2_b_rvalid), 32'(XCHG));
        chk("u2.oor_wr.rdata",  32'(u2_b_rdata),  XCHG ? 32'(0) : 32'('hC));
        u2_op(0, 0, 0, 0, 0, 0, 0);
        chk("u2.quiet.err",     32'(u2_b_err),    32'(0));
        chk("u2.quiet.rvalid",  32'(u2_b_rvalid), 32'(0));
        for (int y = 0; y < 12; y++) begin
            for (int x = 0; x < 20; x++) begin
                e = (x == 19 && y == 11) ? 'hC : 0;
                u2_op(1, 0, x, y, 0, x, y);
                chk($sformatf("u2.scan(%0d,%0d).rdata", x, y), 32'(u2_b_rdata), 32'(e));
                chk($sformatf("u2.scan(%0d,%0d).adata", x, y), 32'(u2_a_data),  32'(e));
            end
        end
        u2_b_req = 0;

        // Requested sweep wipes (31,15); requests in flight get no response.
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 31, 15);
        check_model("clr_start");
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 1000 && busy; k++) begin
            cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)));
            check_model("clr_sweep");
            if (busy) busy_cnt++;
        end
        chk("clr_busy_len", 32'(busy_cnt), 32'(N));
        cycle(1'b1, 1'b0, 31, 15, 0, 1'b0, 31, 15);
        chk("clr_corner.rdata", 32'(b_rdata), 32'(0));
        check_model("clr_corner");

        // Random traffic with occasional clear requests.
        for (int k = 0; k < 2000; k++) begin
            cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(15, 0)), ($urandom_range(299, 0) == 0),
                  int'($urandom_range(31, 0)), int'($urandom_range(15, 0)));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grid_ram.md
Name: grid_ram

Overview:
- Parametrised single-clock grid memory for the game board: WIDTH x HEIGHT cells of CELL_BITS each.
- Port A is a read-only display port with 1-cycle latency.
- Port B is the game-logic read/write port with a ready/valid handshake.
- A built-in clear sequencer fills every cell with CLEAR_VAL after reset and on request, so game logic never sees stale board contents.

Parameters:
- WIDTH, 32, grid columns (>=2)
- HEIGHT, 16, grid rows (>=2)
- CELL_BITS, 4, bits per cell
- CLEAR_VAL, 0, value written to every cell by a clear sweep
- Derived: XW = $clog2(WIDTH), YW = $clog2(HEIGHT), CELLS = WIDTH*HEIGHT, AW = $clog2(CELLS)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_x  in  XW  port A column
- a_y  in  YW  port A row
- a_data  out  CELL_BITS  port A registered read data
- b_req  in  1  port B request
- b_we  in  1  port B: 1 = write, 0 = read
- b_x  in  XW  port B column
- b_y  in  YW  port B row
- b_wdata  in  CELL_BITS  port B write data
- b_ready  out  1  port B can accept a request (= !busy)
- b_rvalid  out  1  one-cycle pulse: b_rdata updated
- b_rdata  out  CELL_BITS  port B read data, held between pulses
- b_err  out  1  one-cycle pulse: accepted request had out-of-range coordinates
- clear_req  in  1  start a clear sweep
- busy  out  1  clear sweep in progress

Behaviour:
- Addressing: addr = y*WIDTH + x, computed at AW bits with no truncation. Coordinates with x>=WIDTH or y>=HEIGHT are out of range (reachable only for non-power-of-2 dimensions).
- Reset (rst_n low, asynchronous): a_data=0, b_rdata=0, b_rvalid=0, b_err=0, clear counter=0, state=CLEAR, busy=1. Memory array is not reset.
- State CLEAR:
  - Each cycle writes CLEAR_VAL to address cnt, then cnt+1.
  - After writing CELLS-1: cnt=0, state=IDLE, busy=0 on the next cycle.
  - Sweep length is exactly CELLS cycles from reset release or from sweep start.
- State IDLE:
  - clear_req=1 moves to CLEAR on the next edge, with cnt=0.
  - clear_req while busy is ignored; it neither restarts nor queues a sweep.
- Port B handshake:
  - A request is accepted on an edge where b_req && b_ready.
  - Read accepted at edge N: b_rdata = mem[addr] and b_rvalid=1 for the cycle following edge N.
  - Write accepted at edge N: mem[addr] = b_wdata at edge N; b_rvalid stays 0.
  - Out-of-range read: b_rdata=0, b_rvalid=1, b_err=1.
  - Out-of-range write: memory unchanged, b_err=1.
  - b_req while !b_ready: dropped, no response.
- clear_req and an accepted b_req in the same IDLE cycle: the B operation completes at that edge, and the sweep begins at the next edge, so its write is then overwritten.
- Port A:
  - a_data <= mem[addr_a] every edge, including during CLEAR. During a sweep, cleared cells show CLEAR_VAL and uncleared cells show old contents.
  - Out-of-range A address: a_data <= 0.
- Same-address collision: a B write and an A read of the same address on one edge give a_data = old value (read-first). Same rule for a clear write colliding with an A read.
- Memory must infer block RAM: no reset on the array, synchronous read.

Optional Feature:
- Macro: GRID_RAM_XCHG_EN.
- Defined: port B write becomes an exchange. b_rdata = old mem[addr], b_rvalid=1 the cycle after acceptance, and the new data is still written. Used for single-cycle snake collision checks. Out-of-range exchange: b_rdata=0, b_rvalid=1, b_err=1, no write.
- Undefined: writes produce no b_rvalid and leave b_rdata unchanged.

Test Plan:
- Reset release, defaults -> busy=1 for exactly 512 cycles, b_ready=0 throughout; then read all 512 cells via port B -> every b_rdata=0.
- Write (x=5,y=3,data=0xA), then read the same cell -> b_rvalid one cycle after acceptance, b_rdata=0xA. Hold a_x=5, a_y=3 -> a_data=0xA one cycle after the write edge.
- Write 0x7 to (31,15), then assert clear_req -> busy high 512 cycles. b_req during the sweep gets no response. After the sweep, (31,15) reads 0x0.
- Non-power-of-2 build WIDTH=20, HEIGHT=12: read (25,3) -> b_rdata=0, b_err=1; write 0xF to (25,3) -> b_err=1 and no cell changes, confirmed by full scan.
- Same-edge B write 0x3 to (0,0) with A reading (0,0) that previously held 0x9 -> a_data=0x9, then 0x3 on the next cycle.
- GRID_RAM_XCHG_EN defined: write 0x2 to a cell holding 0x5 -> b_rvalid=1, b_rdata=0x5; a following read returns 0x2. Undefined: same write -> b_rvalid stays 0.
